// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional statistics counters are enabled with the DMEM_STAT_EN macro.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  localparam int WORD_BYTES = 4;

  typedef logic [WORD_BYTES-1:0] dmem_be_t;

  // Access error: misaligned byte address or word index beyond the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled DEPTH_WORDS x 32 storage with a registered read port.
// The whole array and the read register clear on rst_n.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  dmem_be_t      be,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Commit port: write enabled bytes, and capture read data (0 when not a read).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else if (en) begin
      if (we) begin
        for (int unsigned b = 0; b < WORD_BYTES; b++) begin
          if (be[b]) begin
            mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
      rdata <= re ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port with WAIT_CYCLES
// wait states and one outstanding request. Define DMEM_STAT_EN to add
// saturating load/store counters.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
`ifdef DMEM_STAT_EN
  ,
  output logic [15:0] stat_rd_cnt_o,
  output logic [15:0] stat_wr_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dmem_state_t state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  dmem_be_t    lat_be;

  logic        accept;
  logic        commit;
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  dmem_be_t    cur_be;
  logic        cur_err;

  // With zero wait states the commit edge is the acceptance edge, so the
  // commit fields come straight from the request instead of the latches.
  always_comb begin
    accept    = req_valid_i & req_ready_o;
    commit    = ((state == WAIT) && (cnt == 4'd0)) ||
                ((state == IDLE) && accept && (WAIT_CYCLES == 0));
    cur_write = (state == IDLE) ? req_write_i : lat_write;
    cur_addr  = (state == IDLE) ? req_addr_i  : lat_addr;
    cur_wdata = (state == IDLE) ? req_wdata_i : lat_wdata;
    cur_be    = (state == IDLE) ? req_be_i    : lat_be;
    cur_err   = addr_err(cur_addr, DEPTH_WORDS);
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (commit),
    .we    (commit & cur_write & ~cur_err),
    .re    (~cur_write & ~cur_err),
    .addr  (cur_addr[AW+1:2]),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (rsp_rdata_o)
  );

  // Request/response sequencing FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_be      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write   <= req_write_i;
            lat_addr    <= req_addr_i;
            lat_wdata   <= req_wdata_i;
            lat_be      <= req_be_i;
            req_ready_o <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= cur_err;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= cur_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_STAT_EN
  // Saturating counts of error-free loads and stores, bumped on the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_cnt_o <= '0;
      stat_wr_cnt_o <= '0;
    end else if (commit && !cur_err) begin
      if (cur_write) begin
        if (stat_wr_cnt_o != '1) stat_wr_cnt_o <= stat_wr_cnt_o + 16'd1;
      end else begin
        if (stat_rd_cnt_o != '1) stat_rd_cnt_o <= stat_rd_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 wait states / 256 words and
// 0 wait states / 16 words) checked every cycle against a transaction model.
module tb_data_mem_responder;

  localparam int unsigned NDUT = 2;
  int waitc [NDUT] = '{2, 0};
  int depth [NDUT] = '{256, 16};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid [NDUT];
  logic        req_ready [NDUT];
  logic        req_write [NDUT];
  logic [31:0] req_addr  [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic [3:0]  req_be    [NDUT];
  logic        rsp_valid [NDUT];
  logic        rsp_ready [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];
`ifdef DMEM_STAT_EN
  logic [15:0] st_rd [NDUT];
  logic [15:0] st_wr [NDUT];
`endif

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_write_i(req_write[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
`ifdef DMEM_STAT_EN
    , .stat_rd_cnt_o(st_rd[0]), .stat_wr_cnt_o(st_wr[0])
`endif
  );

  data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_write_i(req_write[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
`ifdef DMEM_STAT_EN
    , .stat_rd_cnt_o(st_rd[1]), .stat_wr_cnt_o(st_wr[1])
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    vectors++;
    miscompares++;
    $display("FAIL timeout %s at %0t", name, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] mmem [NDUT][256];
  bit          m_out [NDUT];
  bit          m_vis [NDUT];
  int          m_delay [NDUT];
  bit          m_w [NDUT];
  logic [31:0] m_a [NDUT];
  logic [31:0] m_wd [NDUT];
  logic [3:0]  m_be [NDUT];
  logic [31:0] m_rdata [NDUT];
  bit          m_err [NDUT];
  int          m_rd [NDUT];
  int          m_wr [NDUT];

  function automatic void model_reset(input int d);
    for (int i = 0; i < 256; i++) mmem[d][i] = '0;
    m_out[d] = 0; m_vis[d] = 0; m_delay[d] = 0;
    m_rdata[d] = '0; m_err[d] = 0; m_rd[d] = 0; m_wr[d] = 0;
  endfunction

  function automatic void model_commit(input int d);
    logic [31:0] mask;
    int idx;
    m_err[d] = (m_a[d] % 4 != 0) || (m_a[d] / 4 >= depth[d]);
    m_rdata[d] = '0;
    if (!m_err[d]) begin
      idx = int'(m_a[d] / 4);
      if (m_w[d]) begin
        mask = '0;
        for (int b = 0; b < 4; b++) if (m_be[d][b]) mask = mask | (32'hFF << (8 * b));
        mmem[d][idx] = (mmem[d][idx] & ~mask) | (m_wd[d] & mask);
        if (m_wr[d] < 65535) m_wr[d]++;
      end else begin
        m_rdata[d] = mmem[d][idx];
        if (m_rd[d] < 65535) m_rd[d]++;
      end
    end
  endfunction

  // Per-cycle compare against the model, then advance the model by one edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (!rst_n) begin
          check($sformatf("d%0d rst ready", d), 32'(req_ready[d]), 32'd1);
          check($sformatf("d%0d rst valid", d), 32'(rsp_valid[d]), 32'd0);
          check($sformatf("d%0d rst rdata", d), rsp_rdata[d], 32'd0);
          check($sformatf("d%0d rst err", d), 32'(rsp_err[d]), 32'd0);
          model_reset(d);
        end else begin
          check($sformatf("d%0d ready", d), 32'(req_ready[d]), 32'(!m_out[d]));
          check($sformatf("d%0d valid", d), 32'(rsp_valid[d]), 32'(m_vis[d]));
          if (m_vis[d]) begin
            check($sformatf("d%0d rdata", d), rsp_rdata[d], m_rdata[d]);
            check($sformatf("d%0d err", d), 32'(rsp_err[d]), 32'(m_err[d]));
          end
          if (m_vis[d] && rsp_ready[d]) begin
            m_vis[d] = 0;
            m_out[d] = 0;
          end else if (m_out[d] && !m_vis[d]) begin
            if (m_delay[d] == 0) begin
              model_commit(d);
              m_vis[d] = 1;
            end else begin
              m_delay[d]--;
            end
          end else if (!m_out[d] && req_valid[d]) begin
            m_out[d] = 1;
            m_w[d] = req_write[d]; m_a[d] = req_addr[d];
            m_wd[d] = req_wdata[d]; m_be[d] = req_be[d];
            if (waitc[d] == 0) begin
              model_commit(d);
              m_vis[d] = 1;
            end else begin
              m_delay[d] = waitc[d] - 1;
            end
          end
        end
`ifdef DMEM_STAT_EN
        check($sformatf("d%0d stat_rd", d), 32'(st_rd[d]), 32'(m_rd[d]));
        check($sformatf("d%0d stat_wr", d), 32'(st_wr[d]), 32'(m_wr[d]));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_req(input int d);
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_be[d]    = 4'($urandom);
  endtask

  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    bit ok;
    rd = '0; er = 1'b0; lat = -1;
    @(posedge clk); #1;
    req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a;
    req_wdata[d] = wd; req_be[d] = be; rsp_ready[d] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[d] && n < 50);
    ok = req_ready[d];
    @(posedge clk); #1;
    idle_req(d);
    if (!ok) begin fail_bound($sformatf("d%0d request handshake", d)); return; end
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[d] && n < 40);
    if (!rsp_valid[d]) begin fail_bound($sformatf("d%0d response", d)); return; end
    lat = n; rd = rsp_rdata[d]; er = rsp_err[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("d%0d hold valid", d), 32'(rsp_valid[d]), 32'd1);
      check($sformatf("d%0d hold ready", d), 32'(req_ready[d]), 32'd0);
    end
    @(posedge clk); #1; rsp_ready[d] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; rsp_ready[d] = 1'b0;
    @(negedge clk);
    check($sformatf("d%0d post-hs ready", d), 32'(req_ready[d]), 32'd1);
    check($sformatf("d%0d post-hs valid", d), 32'(rsp_valid[d]), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr(input int d);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'((4 * $urandom_range(0, 7)) + $urandom_range(1, 3));
    if (r == 1) return 32'(4 * (depth[d] + $urandom_range(0, 3)));
    if (r == 2) return 32'(4 * (depth[d] - 1));
    return 32'(4 * $urandom_range(0, 7));
  endfunction

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      idle_req(d);
      rsp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-wait instance: 3 loads, 2 stores, each with 1-cycle latency.
    xact(1, 0, 32'h4, 32'h0, 4'h0, 0, rd, er, lat);
    check("d1 ld0 lat", 32'(lat), 32'd1);
    check("d1 ld0 rdata", rd, 32'h0);
    xact(1, 1, 32'h4, 32'hAABBCCDD, 4'hF, 0, rd, er, lat);
    check("d1 st0 lat", 32'(lat), 32'd1);
    xact(1, 0, 32'h4, 32'h0, 4'h0, 0, rd, er, lat);
    check("d1 ld1 rdata", rd, 32'hAABBCCDD);
    check("d1 ld1 lat", 32'(lat), 32'd1);
    xact(1, 1, 32'h8, 32'h12345678, 4'h3, 0, rd, er, lat);
    check("d1 st1 lat", 32'(lat), 32'd1);
    xact(1, 0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat);
    check("d1 ld2 rdata", rd, 32'h00005678);
    check("d1 ld2 lat", 32'(lat), 32'd1);
`ifdef DMEM_STAT_EN
    check("d1 stat_rd literal", 32'(st_rd[1]), 32'd3);
    check("d1 stat_wr literal", 32'(st_wr[1]), 32'd2);
`endif

    // Two-wait instance: full store/load, partial store, errors.
    xact(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    check("d0 st lat", 32'(lat), 32'd3);
    check("d0 st rdata", rd, 32'h0);
    check("d0 st err", 32'(er), 32'd0);
    xact(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("d0 ld lat", 32'(lat), 32'd3);
    check("d0 ld rdata", rd, 32'hDEADBEEF);
    check("d0 ld err", 32'(er), 32'd0);
    xact(0, 1, 32'h10, 32'h11223344, 4'b0101, 0, rd, er, lat);
    xact(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("d0 partial rdata", rd, 32'hDE22BE44);
    xact(0, 0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat);
    check("d0 misaligned err", 32'(er), 32'd1);
    check("d0 misaligned rdata", rd, 32'h0);
    xact(0, 1, 32'h400, 32'h55555555, 4'hF, 0, rd, er, lat);
    check("d0 range err", 32'(er), 32'd1);
    check("d0 range rdata", rd, 32'h0);
    xact(0, 0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    check("d0 word0 rdata", rd, 32'h0);
    check("d0 word0 err", 32'(er), 32'd0);
    xact(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat);
    check("d0 be0 err", 32'(er), 32'd0);

    // Backpressure: response held for 5 cycles.
    xact(0, 0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
    check("d0 bp rdata", rd, 32'hDE22BE44);

    // Reset in WAIT of a store: the store must never land.
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h20;
    req_wdata[0] = 32'hCAFEF00D; req_be[0] = 4'hF;
    @(negedge clk);
    check("d0 rst-test accept ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    idle_req(0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("d0 no spurious valid", 32'(rsp_valid[0]), 32'd0);
    end
    xact(0, 0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    check("d0 aborted store rdata", rd, 32'h0);

    // Randomized traffic on both instances.
    for (int k = 0; k < 240; k++) begin
      int d;
      d = (k % 3 == 0) ? 1 : 0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      xact(d, 1'($urandom), rand_addr(d), $urandom, 4'($urandom),
           $urandom_range(0, 3), rd, er, lat);
      check($sformatf("d%0d rand lat", d), 32'(lat), 32'(waitc[d] + 1));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
